eth_tx_frame_scheduler: RTL and testbench

Per-port run controller for the two AXI4-Stream egress channels of the Ethernet traffic generator. It takes run configuration from the AXI-Lite register file (enable, frame length, inter-frame gap, frame count). It issues one start pulse per frame to each port's packet generator. It detects frame completion by monitoring that port's stream tvalid/tready/tlast handshake. Both ports have identical, independent state machines.

---
 rtl/eth_tx_frame_scheduler.sv | 181 ++++++++++++++++++
 tb/tb_eth_tx_frame_scheduler.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_frame_scheduler.sv
// Per-port run controller for the two AXI4-Stream egress channels.
// Each port runs an independent IDLE/START/ACTIVE/GAP state machine. It issues one
// gen_start pulse per frame and counts frames completed on the monitored stream.
module eth_tx_frame_scheduler #(
    parameter int unsigned MIN_LEN        = 60,
    parameter int unsigned MAX_LEN        = 1514,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic        ACLK,
    input  logic        ARESETN,
    input  logic [1:0]  cfg_enable,
    input  logic [15:0] cfg_frame_len,
    input  logic [15:0] cfg_ifg,
    input  logic [31:0] cfg_frame_count,
    input  logic [1:0]  axis_tvalid,
    input  logic [1:0]  axis_tready,
    input  logic [1:0]  axis_tlast,
    output logic [1:0]  gen_start,
    output logic [31:0] gen_len,
    output logic [1:0]  busy,
    output logic [1:0]  done,
    output logic [1:0]  timeout_err,
    output logic [63:0] frames_sent
);

    typedef enum logic [1:0] {
        stIdle,
        stStart,
        stActive,
        stGap
    } portState_t;

    localparam logic [15:0] MinLen     = 16'(MIN_LEN);
    localparam logic [15:0] MaxLen     = 16'(MAX_LEN);
    localparam logic [31:0] TimeoutLim = 32'(TIMEOUT_CYCLES);
    localparam bit          TimeoutOn  = (TIMEOUT_CYCLES != 0);

    // Unsigned 16-bit clamp of the requested length into [MinLen, MaxLen].
    function automatic logic [15:0] clampLen(input logic [15:0] len);
        if (len < MinLen) begin
            return MinLen;
        end
        if (len > MaxLen) begin
            return MaxLen;
        end
        return len;
    endfunction

    logic [15:0] clampedLen;
    logic [1:0]  enQ;
    logic [1:0]  enPrevQ;
    logic [1:0]  enRise;

    assign clampedLen = clampLen(cfg_frame_len);

    // Two-stage enable sampling for rising-edge detection. Reset loads ones so an enable
    // that is already high when reset is released is not taken as a fresh edge.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            enQ     <= 2'b11;
            enPrevQ <= 2'b11;
        end else begin
            enQ     <= cfg_enable;
            enPrevQ <= enQ;
        end
    end

    assign enRise = enQ & ~enPrevQ;

    for (genvar p = 0; p < 2; p++) begin : gPort
        portState_t  stateQ;
        logic        genStartQ;
        logic        busyQ;
        logic        doneQ;
        logic        toErrQ;
        logic [15:0] lenQ;
        logic [15:0] gapCntQ;
        logic [31:0] sentQ;
        logic [31:0] toCntQ;
        logic [31:0] sentInc;
        logic        complete;
        logic        countReached;
        logic        toHit;

        assign complete     = axis_tvalid[p] & axis_tready[p] & axis_tlast[p];
        assign sentInc      = (sentQ == 32'hFFFF_FFFF) ? sentQ : sentQ + 32'd1;
        assign countReached = (cfg_frame_count != 32'd0) && (sentInc == cfg_frame_count);
        // The current ACTIVE cycle is number toCntQ+1; expire on the last allowed one.
        assign toHit        = TimeoutOn && ((toCntQ + 32'd1) == TimeoutLim);

        // Port FSM; all outputs are registered alongside the state.
        always_ff @(posedge ACLK or negedge ARESETN) begin
            if (!ARESETN) begin
                stateQ    <= stIdle;
                genStartQ <= 1'b0;
                busyQ     <= 1'b0;
                doneQ     <= 1'b0;
                toErrQ    <= 1'b0;
                lenQ      <= 16'd0;
                gapCntQ   <= 16'd0;
                sentQ     <= 32'd0;
                toCntQ    <= 32'd0;
            end else begin
                genStartQ <= 1'b0;
                unique case (stateQ)
                    stIdle: begin
                        if (enRise[p]) begin
                            stateQ    <= stStart;
                            genStartQ <= 1'b1;
                            lenQ      <= clampedLen;
                            busyQ     <= 1'b1;
                            doneQ     <= 1'b0;
                            toErrQ    <= 1'b0;
                            sentQ     <= 32'd0;
                        end
                    end

                    stStart: begin
                        // Committed to this frame regardless of enable.
                        stateQ <= stActive;
                        toCntQ <= 32'd0;
                    end

                    stActive: begin
                        if (complete) begin
                            // A completion in the timeout cycle still counts as success.
                            sentQ <= sentInc;
                            if (countReached) begin
                                stateQ <= stIdle;
                                doneQ  <= 1'b1;
                                busyQ  <= 1'b0;
                            end else if (!cfg_enable[p]) begin
                                stateQ <= stIdle;
                                busyQ  <= 1'b0;
                            end else if (cfg_ifg == 16'd0) begin
                                stateQ    <= stStart;
                                genStartQ <= 1'b1;
                                lenQ      <= clampedLen;
                            end else begin
                                stateQ  <= stGap;
                                gapCntQ <= cfg_ifg;
                            end
                        end else if (toHit) begin
                            stateQ <= stIdle;
                            toErrQ <= 1'b1;
                            busyQ  <= 1'b0;
                        end else begin
                            toCntQ <= toCntQ + 32'd1;
                        end
                    end

                    stGap: begin
                        if (!cfg_enable[p]) begin
                            stateQ <= stIdle;
                            busyQ  <= 1'b0;
                        end else if (gapCntQ <= 16'd1) begin
                            stateQ    <= stStart;
                            genStartQ <= 1'b1;
                            lenQ      <= clampedLen;
                        end else begin
                            gapCntQ <= gapCntQ - 16'd1;
                        end
                    end

                    default: begin
                        stateQ <= stIdle;
                        busyQ  <= 1'b0;
                    end
                endcase
            end
        end

        assign gen_start[p]           = genStartQ;
        assign busy[p]                = busyQ;
        assign done[p]                = doneQ;
        assign timeout_err[p]         = toErrQ;
        assign gen_len[16*p +: 16]    = lenQ;
        assign frames_sent[32*p +: 32] = sentQ;
    end

endmodule

// File: tb/tb_eth_tx_frame_scheduler.sv
// Directed bench for eth_tx_frame_scheduler with a 50-cycle frame timeout.
module tb_eth_tx_frame_scheduler;

    logic        tb_ACLK;
    logic        ARESETN;
    logic [1:0]  cfg_enable;
    logic [15:0] cfg_frame_len;
    logic [15:0] cfg_ifg;
    logic [31:0] cfg_frame_count;
    logic [1:0]  axis_tvalid;
    logic [1:0]  axis_tready;
    logic [1:0]  axis_tlast;
    logic [1:0]  gen_start;
    logic [31:0] gen_len;
    logic [1:0]  busy;
    logic [1:0]  done;
    logic [1:0]  timeout_err;
    logic [63:0] frames_sent;

    int nCmp = 0;
    int nErr = 0;
    int startCnt[2] = '{0, 0};
    int w;
    int snap;

    eth_tx_frame_scheduler #(
        .MIN_LEN        (60),
        .MAX_LEN        (1514),
        .TIMEOUT_CYCLES (50)
    ) dut (
        .ACLK            (tb_ACLK),
        .ARESETN         (ARESETN),
        .cfg_enable      (cfg_enable),
        .cfg_frame_len   (cfg_frame_len),
        .cfg_ifg         (cfg_ifg),
        .cfg_frame_count (cfg_frame_count),
        .axis_tvalid     (axis_tvalid),
        .axis_tready     (axis_tready),
        .axis_tlast      (axis_tlast),
        .gen_start       (gen_start),
        .gen_len         (gen_len),
        .busy            (busy),
        .done            (done),
        .timeout_err     (timeout_err),
        .frames_sent     (frames_sent)
    );

    initial tb_ACLK = 1'b0;
    always #5 tb_ACLK = ~tb_ACLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nCmp++;
        assert (obs === exp) else begin
            nErr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample 1ns after the edge and tally start pulses.
    task automatic tick();
        @(posedge tb_ACLK);
        #1;
        for (int p = 0; p < 2; p++) begin
            if (gen_start[p] === 1'b1) startCnt[p]++;
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic waitStart(input int p, input int budget, output int waited);
        waited = 0;
        do begin
            tick();
            waited++;
        end while (gen_start[p] !== 1'b1 && waited < budget);
        chk("start_seen", 64'(gen_start[p]), 64'd1);
    endtask

    task automatic hs(input logic [1:0] m);
        axis_tvalid = m;
        axis_tready = m;
        axis_tlast  = m;
        tick();
        axis_tvalid = 2'b00;
        axis_tready = 2'b00;
        axis_tlast  = 2'b00;
    endtask

    // Single-frame run on port 0 checking the clamped length.
    task automatic runOne(input logic [15:0] len, input logic [15:0] expLen, input string tag);
        int wt;
        cfg_enable[0]   = 1'b0;
        ticks(2);
        cfg_frame_len   = len;
        cfg_frame_count = 32'd1;
        cfg_enable[0]   = 1'b1;
        waitStart(0, 10, wt);
        chk(tag, 64'(gen_len[15:0]), 64'(expLen));
        cfg_frame_len = 16'd500;
        ticks(2);
        hs(2'b01);
        chk({tag, "_held"}, 64'(gen_len[15:0]), 64'(expLen));
        chk({tag, "_done"}, 64'(done[0]), 64'd1);
    endtask

    // Directed sequence.
    initial begin
        ARESETN         = 1'b1;
        cfg_enable      = 2'b00;
        cfg_frame_len   = 16'd0;
        cfg_ifg         = 16'd0;
        cfg_frame_count = 32'd0;
        axis_tvalid     = 2'b00;
        axis_tready     = 2'b00;
        axis_tlast      = 2'b00;
        #2 ARESETN = 1'b0;
        #1;
        chk("rst_flags", 64'({gen_start, busy, done, timeout_err}), 64'd0);
        chk("rst_gen_len", 64'(gen_len), 64'd0);
        chk("rst_frames", frames_sent, 64'd0);
        ticks(2);
        ARESETN = 1'b1;
        ticks(2);

        // Handshakes while idle are not counted.
        axis_tvalid = 2'b11;
        axis_tready = 2'b11;
        axis_tlast  = 2'b11;
        ticks(3);
        axis_tvalid = 2'b00;
        axis_tready = 2'b00;
        axis_tlast  = 2'b00;
        tick();
        chk("idle_hs_frames", frames_sent, 64'd0);
        chk("idle_hs_busy", 64'(busy), 64'd0);

        // Three-frame run on port 0 with a 4-cycle gap.
        cfg_frame_len   = 16'd100;
        cfg_ifg         = 16'd4;
        cfg_frame_count = 32'd3;
        cfg_enable      = 2'b01;
        waitStart(0, 10, w);
        chk("t1_latency", 64'(w), 64'd2);
        chk("t1_gen_len", 64'(gen_len[15:0]), 64'd100);
        chk("t1_busy", 64'(busy), 64'd1);
        for (int f = 0; f < 3; f++) begin
            ticks(10);
            hs(2'b01);
            if (f < 2) begin
                waitStart(0, 20, w);
                chk("t1_spacing", 64'(w), 64'd4);
            end
        end
        chk("t1_done", 64'(done), 64'd1);
        chk("t1_busy_end", 64'(busy), 64'd0);
        chk("t1_frames", 64'(frames_sent[31:0]), 64'd3);
        chk("t1_starts", 64'(startCnt[0]), 64'd3);
        chk("t1_p1_flags", 64'({busy[1], done[1], timeout_err[1], gen_start[1]}), 64'd0);
        chk("t1_p1_regs", {gen_len[31:16], frames_sent[63:32]}, 64'd0);
        chk("t1_p1_starts", 64'(startCnt[1]), 64'd0);
        ticks(10);
        chk("t1_no_rerun", 64'(startCnt[0]), 64'd3);

        // Length clamping.
        runOne(16'd20, 16'd60, "t2_len_short");
        runOne(16'd2000, 16'd1514, "t2_len_long");
        runOne(16'd0, 16'd60, "t2_len_zero");

        // Continuous back-to-back on both ports, then port 1 stops.
        cfg_enable      = 2'b00;
        ticks(2);
        cfg_ifg         = 16'd0;
        cfg_frame_count = 32'd0;
        cfg_frame_len   = 16'd64;
        cfg_enable      = 2'b11;
        waitStart(0, 10, w);
        chk("t3_both_start", 64'(gen_start), 64'd3);
        ticks(3);
        hs(2'b11);
        chk("t3_b2b", 64'(gen_start), 64'd3);
        tick();
        cfg_enable[1] = 1'b0;
        tick();
        chk("t3_p1_finishing", 64'(busy), 64'd3);
        hs(2'b11);
        chk("t3_p1_no_start", 64'(gen_start), 64'd1);
        chk("t3_busy", 64'(busy), 64'd1);
        chk("t3_done", 64'(done), 64'd0);
        chk("t3_frames", frames_sent, {32'd2, 32'd2});
        ticks(4);
        hs(2'b01);
        chk("t3_p0_b2b", 64'(gen_start), 64'd1);
        chk("t3_p0_frames", 64'(frames_sent[31:0]), 64'd3);
        cfg_enable[0] = 1'b0;
        tick();
        hs(2'b01);
        chk("t3_stop_busy", 64'(busy), 64'd0);
        chk("t3_stop_done", 64'(done), 64'd0);
        chk("t3_stop_frames", 64'(frames_sent[31:0]), 64'd4);

        // Timeout after 50 ACTIVE cycles.
        ticks(2);
        cfg_frame_count = 32'd1;
        cfg_enable      = 2'b01;
        waitStart(0, 10, w);
        ticks(50);
        chk("t4_before_to", 64'({timeout_err[0], busy[0]}), 64'b01);
        tick();
        chk("t4_timeout", 64'(timeout_err), 64'd1);
        chk("t4_busy", 64'(busy), 64'd0);
        chk("t4_done", 64'(done), 64'd0);
        cfg_enable = 2'b00;
        ticks(2);
        chk("t4_sticky", 64'(timeout_err), 64'd1);
        cfg_enable = 2'b01;
        waitStart(0, 10, w);
        chk("t4_cleared", 64'(timeout_err), 64'd0);
        tick();
        hs(2'b01);
        chk("t4_rerun_done", 64'(done), 64'd1);

        // Asynchronous reset during the gap.
        cfg_enable = 2'b00;
        ticks(2);
        cfg_frame_count = 32'd5;
        cfg_ifg         = 16'd8;
        cfg_frame_len   = 16'd100;
        cfg_enable      = 2'b01;
        waitStart(0, 10, w);
        ticks(3);
        hs(2'b01);
        ticks(2);
        chk("t5_in_gap", {31'd0, busy[0], frames_sent[31:0]}, {31'd0, 1'b1, 32'd1});
        ARESETN = 1'b0;
        #1;
        chk("t5_rst_flags", 64'({gen_start, busy, done, timeout_err}), 64'd0);
        chk("t5_rst_len", 64'(gen_len), 64'd0);
        chk("t5_rst_frames", frames_sent, 64'd0);
        snap = startCnt[0];
        ticks(3);
        ARESETN = 1'b1;
        ticks(20);
        chk("t5_no_start", 64'(startCnt[0]), 64'(snap));
        chk("t5_idle", 64'(busy), 64'd0);
        cfg_enable = 2'b00;
        ticks(2);
        cfg_enable = 2'b01;
        waitStart(0, 10, w);
        chk("t5_fresh_edge", 64'(w), 64'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
